// File: rtl/pipe_addsub_pkg.sv
// -----------------------------------------------------------------------------
// pipe_addsub_pkg
//
// Shared definitions for the pipelined adder/subtractor:
//   seg_width()  - bits handled by each pipeline segment (WIDTH / STAGES)
//   params_ok()  - elaboration-time legality of a WIDTH/STAGES pair
//   full_adder() - the 1-bit full-adder cell the segment adders are built from
// -----------------------------------------------------------------------------
package pipe_addsub_pkg;

    // Width of one carry-chain segment. A zero STAGES is reported by
    // params_ok(); this only avoids a division by zero before that check.
    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    // A legal configuration splits the chain into equal, non-empty segments.
    function automatic logic params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // 1-bit full adder cell, returned as {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic a, input logic b,
                                              input logic ci);
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/add_seg.sv
// -----------------------------------------------------------------------------
// add_seg
//
// Combinational SEG-bit ripple-carry adder made of full-adder cells. One of
// these sits in every pipeline segment of pipe_addsub.
//
// Ports:
//   a, b      [SEG-1:0]  operand slices (b already inverted for subtraction)
//   ci                   carry into bit 0
//   s         [SEG-1:0]  sum slice
//   co                   carry out of the top bit
//   c_msb_in             carry into the top bit; with co it gives signed
//                        overflow when this is the most significant segment
// -----------------------------------------------------------------------------
module add_seg
    import pipe_addsub_pkg::*;
#(
    parameter int SEG = 11
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    // c[i] is the carry into bit i; c[SEG] leaves the segment.
    logic [SEG:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        assign {c[i+1], s[i]} = full_adder(a[i], b[i], c[i]);
    end

    assign co       = c[SEG];
    assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
//
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit carry chain is cut
// into STAGES equal segments with a register boundary after each segment, so
// the result appears STAGES cycles after the operands are accepted.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready  operand handshake
//   A, B   [WIDTH:1]    operands
//   cin                 carry-in for addition (ignored when sub=1)
//   sub                 0: S = A + B + cin, 1: S = A - B
//   out_valid, out_ready result handshake
//   S      [WIDTH:1]    sum/difference
//   cout                carry out of bit WIDTH (sub=1: 1 means no borrow)
//   ovf                 two's-complement overflow
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The whole pipeline advances together on en = ~out_valid | out_ready, and
// in_ready is exactly en, so in_ready never depends on in_valid. A source that
// sees in_ready low must keep in_valid and its operands unchanged. S, cout and
// ovf stay frozen while out_valid is high and out_ready is low.
//
// Per stage k the registers hold: the result slices already produced, the
// operand slices still to be consumed (skewed along with the data), the carry
// leaving segment k, and a valid bit. Bubbles travel like data with valid=0 and
// do not overwrite data registers, so outputs keep the last valid result.
// -----------------------------------------------------------------------------
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 22,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:1]   A,
    input  logic [WIDTH:1]   B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:1]   S,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipe_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Input conditioning: subtraction is A + ~B + 1.
    logic             en;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign a_in  = A;
    assign b_eff = B ^ {WIDTH{sub}};
    assign c_eff = sub | cin;

    // Stage registers, index k = stage k+1.
    logic [STAGES-1:0][WIDTH-1:0] a_r;
    logic [STAGES-1:0][WIDTH-1:0] b_r;
    logic [STAGES-1:0][WIDTH-1:0] s_r;
    logic [STAGES-1:0]            c_r;
    logic [STAGES-1:0]            v_r;
    logic                         ovf_r;

    // Source of each stage: index 0 is the input port, index k+1 is stage k.
    // Building these as one concatenation keeps the first stage regular.
    logic [STAGES:0][WIDTH-1:0] a_src;
    logic [STAGES:0][WIDTH-1:0] b_src;
    logic [STAGES:0][WIDTH-1:0] s_src;
    logic [STAGES:0]            c_src;
    logic [STAGES:0]            v_src;

    assign a_src = {a_r, a_in};
    assign b_src = {b_r, b_eff};
    assign s_src = {s_r, {WIDTH{1'b0}}};
    assign c_src = {c_r, c_eff};
    assign v_src = {v_r, in_valid};

    // Segment adders.
    logic [STAGES-1:0][SEG-1:0] seg_a;
    logic [STAGES-1:0][SEG-1:0] seg_b;
    logic [STAGES-1:0][SEG-1:0] seg_s;
    logic [STAGES-1:0]          seg_co;
    logic [STAGES-1:0]          seg_cm;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        assign seg_a[k] = a_src[k][k*SEG +: SEG];
        assign seg_b[k] = b_src[k][k*SEG +: SEG];

        add_seg #(
            .SEG(SEG)
        ) u_add_seg (
            .a        (seg_a[k]),
            .b        (seg_b[k]),
            .ci       (c_src[k]),
            .s        (seg_s[k]),
            .co       (seg_co[k]),
            .c_msb_in (seg_cm[k])
        );
    end

    // Result word leaving stage k: earlier slices carried forward, slice k new.
    logic [STAGES-1:0][WIDTH-1:0] s_next;

    always_comb begin
        s_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_next[k]                = s_src[k];
            s_next[k][k*SEG +: SEG]  = seg_s[k];
        end
    end

    assign en = ~v_r[STAGES-1] | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            c_r   <= '0;
            v_r   <= '0;
            ovf_r <= 1'b0;
        end else if (en) begin
            v_r <= v_src[STAGES-1:0];
            for (int k = 0; k < STAGES; k++) begin
                // A bubble moves the valid bit only, leaving the data of the
                // last real result in place.
                if (v_src[k]) begin
                    a_r[k] <= a_src[k];
                    b_r[k] <= b_src[k];
                    s_r[k] <= s_next[k];
                    c_r[k] <= seg_co[k];
                end
            end
            if (v_src[STAGES-1]) begin
                ovf_r <= seg_co[STAGES-1] ^ seg_cm[STAGES-1];
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = v_r[STAGES-1];
    assign S         = s_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;

    // Operand slices already consumed, the zero seed of the result word and
    // the inner-segment MSB carries have no reader; they fold into this sink.
    logic unused_bits;
    assign unused_bits = ^{a_src, b_src, s_src, seg_cm};

endmodule

// File: tb/tb_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipe_addsub
//
// Bench for pipe_addsub at WIDTH=22 with three instances: STAGES = 1, 2, 11.
// Instance index u selects the configuration in every task. The reference
// model keeps, per instance, a line of STAGES valid slots advancing under the
// pipeline enable rule, plus a queue of expected {ovf, cout, S} values
// computed with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_pipe_addsub;

    localparam int W = 22;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         cin       [3];
    logic         sub       [3];
    logic [W-1:0] a_in      [3];
    logic [W-1:0] b_in      [3];
    wire          in_ready  [3];
    wire          out_valid [3];
    wire          cout      [3];
    wire          ovf       [3];
    wire  [W-1:0] s_out     [3];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic         mv       [3][11];
    logic [23:0]  last_out [3];
    logic [23:0]  exp_q    [3][$];

    initial forever #5 clk = ~clk;

    for (genvar u = 0; u < 3; u++) begin : g_dut
        pipe_addsub #(
            .WIDTH  (W),
            .STAGES (u == 0 ? 1 : (u == 1 ? 2 : 11))
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[u]),
            .in_ready  (in_ready[u]),
            .A         (a_in[u]),
            .B         (b_in[u]),
            .cin       (cin[u]),
            .sub       (sub[u]),
            .out_valid (out_valid[u]),
            .out_ready (out_ready[u]),
            .S         (s_out[u]),
            .cout      (cout[u]),
            .ovf       (ovf[u])
        );
    end

    function automatic int stages_of(input int u);
        case (u)
            0:       return 1;
            1:       return 2;
            default: return 11;
        endcase
    endfunction

    // {ovf, cout, S} from unsigned and signed integer arithmetic.
    function automatic logic [23:0] ref_result(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic ci, input logic sb);
        longint ua, ub, sa, sbv, u_res, s_res;
        logic   o;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = a[W-1] ? ua - 64'sd4194304 : ua;
        sbv = b[W-1] ? ub - 64'sd4194304 : ub;
        if (sb) begin
            u_res = ua + 64'sd4194304 - ub;
            s_res = sa - sbv;
        end else begin
            u_res = ua + ub + longint'(ci);
            s_res = sa + sbv + longint'(ci);
        end
        o = (s_res < -64'sd2097152) || (s_res > 64'sd2097151);
        return {o, u_res[22], u_res[21:0]};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < 11; k++) mv[u][k] = 1'b0;
            last_out[u] = '0;
            exp_q[u].delete();
        end
    endtask

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic model_step();
        for (int u = 0; u < 3; u++) begin
            int   ns;
            logic head;
            ns   = stages_of(u);
            head = mv[u][ns-1];
            if (!head || out_ready[u]) begin
                if (head && exp_q[u].size() > 0) last_out[u] = exp_q[u].pop_front();
                for (int k = ns - 1; k > 0; k--) mv[u][k] = mv[u][k-1];
                mv[u][0] = in_valid[u];
                if (in_valid[u])
                    exp_q[u].push_back(ref_result(a_in[u], b_in[u], cin[u], sub[u]));
            end
        end
    endtask

    // One clock: rising edge, model update, then back to the falling edge
    // where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drain(input int u);
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b1;
        repeat (stages_of(u) + 2) tick();
    endtask

    // Present one operand set on an idle pipeline and wait for its result.
    task automatic issue_and_wait(input int u, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic ci,
                                  input logic sb, output logic [23:0] res,
                                  output int lat);
        a_in[u] = a; b_in[u] = b; cin[u] = ci; sub[u] = sb;
        in_valid[u]  = 1'b1;
        out_ready[u] = 1'b1;
        tick();
        in_valid[u] = 1'b0;
        lat = 1;
        while (!out_valid[u] && lat < 40) begin
            tick();
            lat++;
        end
        res = {ovf[u], cout[u], s_out[u]};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; out_ready[u] = 1'b1;
            cin[u] = 1'b0; sub[u] = 1'b0; a_in[u] = '0; b_in[u] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int u = 0; u < 3; u++) begin
            n_checks++;
            if (out_valid[u] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", u, out_valid[u]);
            end
            n_checks++;
            if (in_ready[u] !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 1", u, in_ready[u]);
            end
            n_checks++;
            if ({ovf[u], cout[u], s_out[u]} !== 24'h0) begin
                n_errors++;
                $display("FAIL reset_outputs[%0d]: got %h expected 000000", u,
                         {ovf[u], cout[u], s_out[u]});
            end
        end
    endtask

    task automatic test_carry_wrap();
        logic [23:0] res;
        int          lat;
        for (int u = 0; u < 3; u++) begin
            issue_and_wait(u, 22'h3FFFFF, 22'h000001, 1'b0, 1'b0, res, lat);
            n_checks++;
            if (lat != stages_of(u)) begin
                n_errors++;
                $display("FAIL carry_latency[%0d]: got %0d expected %0d", u, lat, stages_of(u));
            end
            n_checks++;
            if (res !== {1'b0, 1'b1, 22'h000000}) begin
                n_errors++;
                $display("FAIL carry_wrap[%0d]: got %h expected %h", u, res, {2'b01, 22'h0});
            end
        end
    endtask

    task automatic test_overflow();
        logic [23:0] res;
        int          lat;
        issue_and_wait(1, 22'h1FFFFF, 22'h000001, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== {1'b1, 1'b0, 22'h200000}) begin
            n_errors++;
            $display("FAIL ovf_add: got %h expected %h", res, {2'b10, 22'h200000});
        end
        issue_and_wait(1, 22'h200000, 22'h000001, 1'b0, 1'b1, res, lat);
        n_checks++;
        if (res !== {1'b1, 1'b1, 22'h1FFFFF}) begin
            n_errors++;
            $display("FAIL ovf_sub: got %h expected %h", res, {2'b11, 22'h1FFFFF});
        end
        n_checks++;
        if (lat != 2) begin
            n_errors++;
            $display("FAIL ovf_sub_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_subtract();
        logic [23:0] res;
        int          lat;
        // cin is set to 1 here and must have no effect on a subtraction.
        issue_and_wait(1, 22'd5, 22'd7, 1'b1, 1'b1, res, lat);
        n_checks++;
        if (res !== {1'b0, 1'b0, 22'h3FFFFE}) begin
            n_errors++;
            $display("FAIL sub_borrow: got %h expected %h", res, {2'b00, 22'h3FFFFE});
        end
        issue_and_wait(1, 22'd7, 22'd5, 1'b0, 1'b1, res, lat);
        n_checks++;
        if (res !== {1'b0, 1'b1, 22'd2}) begin
            n_errors++;
            $display("FAIL sub_no_borrow: got %h expected %h", res, {2'b01, 22'd2});
        end
        // Addition with cin=1 to show the carry-in is honoured there.
        issue_and_wait(1, 22'd5, 22'd7, 1'b1, 1'b0, res, lat);
        n_checks++;
        if (res !== {1'b0, 1'b0, 22'd13}) begin
            n_errors++;
            $display("FAIL add_cin: got %h expected %h", res, {2'b00, 22'd13});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got[$];
        int           sent;
        int           cyc;
        sent = 0;
        cyc  = 0;
        drain(1);
        b_in[1] = 22'd10; cin[1] = 1'b0; sub[1] = 1'b0;
        while ((sent < 4 || got.size() < 4) && cyc < 40) begin
            in_valid[1]  = (sent < 4);
            a_in[1]      = W'(sent + 1);
            out_ready[1] = !(cyc >= 2 && cyc < 7);
            #1;
            if (cyc >= 2 && cyc < 7) begin
                n_checks++;
                if (out_valid[1] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stall_out_valid cyc %0d: got %b expected 1", cyc, out_valid[1]);
                end
                n_checks++;
                if (in_ready[1] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_in_ready cyc %0d: got %b expected 0", cyc, in_ready[1]);
                end
                n_checks++;
                if (s_out[1] !== 22'd11) begin
                    n_errors++;
                    $display("FAIL stall_hold cyc %0d: got %0d expected 11", cyc, s_out[1]);
                end
            end
            if (out_valid[1] && out_ready[1]) got.push_back(s_out[1]);
            if (in_valid[1] && in_ready[1]) sent++;
            tick();
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got.size()) begin
                n_errors++;
                $display("FAIL stream_result %0d: got none expected %0d", i, 11 + i);
            end else if (got[i] !== W'(11 + i)) begin
                n_errors++;
                $display("FAIL stream_result %0d: got %0d expected %0d", i, got[i], 11 + i);
            end
        end
        drain(1);
    endtask

    task automatic test_reset_mid();
        logic [23:0] res;
        int          lat;
        int          stale;
        drain(1);
        out_ready[1] = 1'b1;
        in_valid[1] = 1'b1; cin[1] = 1'b0; sub[1] = 1'b0;
        a_in[1] = 22'h1FFFFF; b_in[1] = 22'h000001;
        tick();
        a_in[1] = 22'h3FFFFF; b_in[1] = 22'h000002;
        tick();
        in_valid[1] = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out_valid[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_out_valid: got %b expected 0", out_valid[1]);
        end
        n_checks++;
        if ({ovf[1], cout[1], s_out[1]} !== 24'h0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got %h expected 000000", {ovf[1], cout[1], s_out[1]});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (12) begin
            tick();
            if (out_valid[1]) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_errors++;
            $display("FAIL midreset_stale: got %0d valid cycles expected 0", stale);
        end
        issue_and_wait(1, 22'd5, 22'd7, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (res !== {2'b00, 22'd12} || lat != 2) begin
            n_errors++;
            $display("FAIL midreset_recover: got %h lat %0d expected %h lat 2", res, lat, {2'b00, 22'd12});
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 22'h000000;
            1:       return 22'h3FFFFF;
            2:       return 22'h200000;
            3:       return 22'h1FFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int u = 0; u < 3; u++) begin
            int          ns;
            logic        pend;
            logic        head;
            logic [23:0] exp_v;
            ns   = stages_of(u);
            pend = 1'b0;
            drain(u);
            for (int c = 0; c < 400; c++) begin
                head = mv[u][ns-1];
                n_checks++;
                if (out_valid[u] !== head) begin
                    n_errors++;
                    $display("FAIL rand_out_valid[%0d] cyc %0d: got %b expected %b", u, c, out_valid[u], head);
                end
                exp_v = (head && exp_q[u].size() > 0) ? exp_q[u][0] : last_out[u];
                n_checks++;
                if ({ovf[u], cout[u], s_out[u]} !== exp_v) begin
                    n_errors++;
                    $display("FAIL rand_result[%0d] cyc %0d: got %h expected %h", u, c,
                             {ovf[u], cout[u], s_out[u]}, exp_v);
                end
                if (!pend) begin
                    in_valid[u] = ($urandom_range(0, 3) != 0);
                    a_in[u]     = pick_operand();
                    b_in[u]     = pick_operand();
                    cin[u]      = 1'($urandom_range(0, 1));
                    sub[u]      = 1'($urandom_range(0, 1));
                end
                out_ready[u] = ($urandom_range(0, 3) != 0);
                #1;
                n_checks++;
                if (in_ready[u] !== (!head || out_ready[u])) begin
                    n_errors++;
                    $display("FAIL rand_in_ready[%0d] cyc %0d: got %b expected %b", u, c,
                             in_ready[u], !head || out_ready[u]);
                end
                pend = in_valid[u] && !(!head || out_ready[u]);
                tick();
            end
            drain(u);
            n_checks++;
            if (exp_q[u].size() != 0 || out_valid[u] !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_drain[%0d]: got %0d pending expected 0", u, exp_q[u].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
